// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the round-robin multiplexer/arbiter.
//   - MODE_RR / MODE_FIXED : encodings of the arbitration mode input.
//   - clog2                : elaboration-time ceiling log2, used to size the
//                            channel-index fields.
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Smallest r with (1 << r) >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational request picker.
//   Round-robin mode searches from base+1 upward and wraps.
//   Fixed mode always searches from index 0.
//   Implementation: rotate the request vector so the search start sits at bit 0,
//   take the lowest set bit, then add the rotation back onto the index.
// Ports
//   req      in   CH    request vector (one bit per channel)
//   base     in   SELW  most recently granted channel
//   mode     in   1     MODE_RR or MODE_FIXED
//   gnt_idx  out  SELW  granted channel index (0 when gnt_vld=0)
//   gnt_vld  out  1     at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import mux_pkg::*;
#(
  parameter  int CH   = 4,
  localparam int SELW = clog2(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] base,
  input  logic            mode,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [2*CH-1:0] req_dbl;
  logic [CH-1:0]   rot;
  logic [SELW-1:0] enc;
  int              offset;
  int              sum;

  always_comb begin
    // Search start: base+1 (wrapping) in round-robin mode, 0 in fixed mode.
    offset = 0;
    if (mode == MODE_RR) begin
      offset = (int'(base) >= CH - 1) ? 0 : int'(base) + 1;
    end

    // Rotating a duplicated vector avoids any modulo indexing.
    req_dbl = {req, req} >> offset;
    rot     = req_dbl[CH-1:0];

    // Lowest set bit wins; descending scan leaves the lowest match last.
    enc     = '0;
    gnt_vld = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc     = SELW'(i);
        gnt_vld = 1'b1;
      end
    end

    // Undo the rotation.
    sum = int'(enc) + offset;
    if (sum >= CH) begin
      sum = sum - CH;
    end
    gnt_idx = gnt_vld ? SELW'(sum) : '0;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//   CH-to-1 data multiplexer with built-in arbitration and a registered output.
//   Channels and output use valid/ready. Selection is round-robin (mode=0) or
//   fixed priority with the lowest index winning (mode=1).
// Ports
//   clk        in   1      clock, posedge
//   rst        in   1      asynchronous reset, active-high
//   in_data    in   CH*N   channel i at in_data[i*N +: N]
//   in_valid   in   CH     channel i presents data
//   in_ready   out  CH     one-hot (or zero) accept strobe
//   mode       in   1      0 = round-robin, 1 = fixed priority
//   out_data   out  N      registered selected data
//   out_sel    out  SELW   channel that produced out_data
//   out_valid  out  1      output register holds a word
//   out_ready  in   1      consumer accepts the word
// -----------------------------------------------------------------------------
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int CH   = 4,
  localparam int SELW = clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  output logic [N-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]    out_data_q,   out_data_d;
  logic [SELW-1:0] out_sel_q,    out_sel_d;
  logic            out_valid_q,  out_valid_d;
  logic [SELW-1:0] last_grant_q, last_grant_d;

  logic [SELW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            load;
  logic            xfer;
  logic [N-1:0]    gnt_data;

  rr_pick #(
    .CH (CH)
  ) u_pick (
    .req     (in_valid),
    .base    (last_grant_q),
    .mode    (mode),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    // The output register can take a word when empty or being drained now,
    // which gives back-to-back transfers with no bubble.
    load = !out_valid_q || out_ready;
    // gnt_vld implies in_valid[gnt_idx], so this is the accepted handshake.
    xfer = load && gnt_vld;

    gnt_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data = in_data[i*N +: N];
      end
    end

    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end

    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;

    if (xfer) begin
      out_data_d   = gnt_data;
      out_sel_d    = gnt_idx;
      out_valid_d  = 1'b1;
      last_grant_d = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it: data and sel keep their values.
      out_valid_d  = 1'b0;
    end
  end

  // Output register and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      // Start at CH-1 so the first round-robin search begins at channel 0.
      last_grant_q <= SELW'(CH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int N    = 4;
  localparam int CH   = 4;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [N-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_valid;
  logic            out_ready;

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .N  (N),
    .CH (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [N-1:0]    data;
    logic [SELW-1:0] sel;
  } word_t;

  word_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  logic [N-1:0] dtab [CH] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  // Reference model state
  logic          m_valid;
  int            m_last;
  logic          m_new;
  word_t         m_cur;
  logic [CH-1:0] e_ready;
  int            e_gnt;
  logic          e_xfer;

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = CH - 1;
    m_new   = 1'b0;
    m_cur   = '0;
    exp_q.delete();
  endtask

  // Expected grant by a straightforward scan over channel indices.
  task automatic model_eval();
    logic          load;
    logic [CH-1:0] one;
    one   = 1;
    e_gnt = -1;
    load  = !m_valid || out_ready;
    if (mode) begin
      for (int i = 0; i < CH; i++)
        if (in_valid[i] && e_gnt < 0) e_gnt = i;
    end else begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last + k) % CH;
        if (in_valid[c] && e_gnt < 0) e_gnt = c;
      end
    end
    e_xfer  = load && (e_gnt >= 0);
    e_ready = e_xfer ? (one << e_gnt) : '0;
  endtask

  // Push expected word when a transfer is due, then advance one clock.
  task automatic tick();
    word_t w;
    if (e_xfer) begin
      w.data = in_data[e_gnt*N +: N];
      w.sel  = SELW'(e_gnt);
      exp_q.push_back(w);
    end
    @(posedge clk);
    if (e_xfer) begin
      m_last  = e_gnt;
      m_valid = 1'b1;
      m_new   = 1'b1;
    end else begin
      m_new = 1'b0;
      if (out_ready) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic take_expected();
    if (m_new && exp_q.size() > 0) m_cur = exp_q.pop_front();
    m_new = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 4'b0000) begin bad++; $display("FAIL reset_data: got %b want 0000", out_data); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_rr_sweep();
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1; model_eval();
      total++; if (in_ready !== e_ready) begin bad++; $display("FAIL rr_in_ready[%0d]: got %b want %b", c, in_ready, e_ready); end
      tick(); take_expected();
      total++;
      if (out_valid !== 1'b1 || out_sel !== SELW'(c % CH) || out_data !== dtab[c % CH]) begin
        bad++;
        $display("FAIL rr_out[%0d]: got v=%b sel=%0d data=%b want v=1 sel=%0d data=%b",
                 c, out_valid, out_sel, out_data, c % CH, dtab[c % CH]);
      end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1; model_eval();
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL fixed_in_ready[%0d]: got %b want 0001", c, in_ready); end
      tick(); take_expected();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'b0001) begin
        bad++;
        $display("FAIL fixed_out[%0d]: got v=%b sel=%0d data=%b want v=1 sel=0 data=0001",
                 c, out_valid, out_sel, out_data);
      end
    end
  endtask

  task automatic test_stall();
    mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b1;
    #1; model_eval();
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL stall_load_ready: got %b want 0100", in_ready); end
    tick(); take_expected();
    total++; if (out_sel !== 2'd2 || out_data !== 4'b0111) begin bad++; $display("FAIL stall_load_out: got sel=%0d data=%b want sel=2 data=0111", out_sel, out_data); end
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1; model_eval();
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0000", c, in_ready); end
      tick(); take_expected();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'b0111 || out_data !== m_cur.data) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got v=%b sel=%0d data=%b want v=1 sel=2 data=0111",
                 c, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1; model_eval();
    total++; if (in_ready !== 4'b1000 || in_ready !== e_ready) begin bad++; $display("FAIL stall_release_ready: got %b want 1000", in_ready); end
    tick(); take_expected();
    total++; if (out_sel !== 2'd3 || out_data !== 4'b1111) begin bad++; $display("FAIL stall_release_out: got sel=%0d data=%b want sel=3 data=1111", out_sel, out_data); end
  endtask

  task automatic test_wrap();
    logic [CH-1:0] vpat [3] = '{4'b1000, 4'b0010, 4'b1010};
    logic [CH-1:0] rpat [3] = '{4'b1000, 4'b0010, 4'b1000};
    mode = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = vpat[c];
      #1; model_eval();
      total++; if (in_ready !== rpat[c] || in_ready !== e_ready) begin bad++; $display("FAIL wrap_in_ready[%0d]: got %b want %b", c, in_ready, rpat[c]); end
      tick(); take_expected();
      total++;
      if (out_valid !== 1'b1 || out_sel !== m_cur.sel || out_data !== m_cur.data) begin
        bad++;
        $display("FAIL wrap_out[%0d]: got v=%b sel=%0d data=%b want v=1 sel=%0d data=%b",
                 c, out_valid, out_sel, out_data, m_cur.sel, m_cur.data);
      end
    end
    // Drain with no requests: valid drops, data and sel hold.
    in_valid = 4'b0000;
    #1; model_eval();
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL drain_in_ready: got %b want 0000", in_ready); end
    tick(); take_expected();
    total++;
    if (out_valid !== 1'b0 || out_sel !== 2'd3 || out_data !== 4'b1111) begin
      bad++;
      $display("FAIL drain_out: got v=%b sel=%0d data=%b want v=0 sel=3 data=1111", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1; model_eval();
      tick(); take_expected();
    end
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd1) begin bad++; $display("FAIL midrst_pre: got v=%b sel=%0d want v=1 sel=1", out_valid, out_sel); end
    rst = 1'b1;
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0 || out_data !== 4'b0000 || out_sel !== 2'd0) begin
      bad++; $display("FAIL midrst_async: got v=%b sel=%0d data=%b want v=0 sel=0 data=0000", out_valid, out_sel, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1; model_eval();
    total++; if (in_ready !== 4'b0001 || in_ready !== e_ready) begin bad++; $display("FAIL midrst_first_ready: got %b want 0001", in_ready); end
    tick(); take_expected();
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'b0001) begin
      bad++; $display("FAIL midrst_first_out: got v=%b sel=%0d data=%b want v=1 sel=0 data=0001", out_valid, out_sel, out_data);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    mode      = 1'b0;
    in_data   = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
    test_reset();
    test_rr_sweep();
    test_fixed();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
